// File: rtl/exec_mem_unit.sv
// EX/MEM slice of the 5-stage MIPS pipeline: ALU-control decode, 32-bit ALU
// and a DEPTH-word data memory with synchronous clear.
module exec_mem_unit #(
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [3:0]               alu_op,
  input  logic [5:0]               func_code,
  input  logic [31:0]              bus_a,
  input  logic [31:0]              bus_b,
  input  logic [4:0]               shamt,
  output logic [3:0]               alu_ctrl,
  output logic [31:0]              alu_out,
  output logic                     zero,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic [31:0]              mem_rdata
);
  logic [3:0]  w_alu_ctrl;
  logic [31:0] w_alu_out;
  logic [31:0] r_mem [DEPTH];

  // 4'b1111 from main control means "R-type, look at the function field"
  always_comb begin
    w_alu_ctrl = alu_op;
    if (alu_op == 4'b1111) begin
      case (func_code)
        6'b000000: w_alu_ctrl = 4'b0011;
        6'b000010: w_alu_ctrl = 4'b0100;
        6'b000011: w_alu_ctrl = 4'b1101;
        6'b100000: w_alu_ctrl = 4'b0010;
        6'b100001: w_alu_ctrl = 4'b1000;
        6'b100010: w_alu_ctrl = 4'b0110;
        6'b100011: w_alu_ctrl = 4'b1001;
        6'b100100: w_alu_ctrl = 4'b0000;
        6'b100101: w_alu_ctrl = 4'b0001;
        6'b100110: w_alu_ctrl = 4'b1010;
        6'b100111: w_alu_ctrl = 4'b1100;
        6'b101010: w_alu_ctrl = 4'b0111;
        6'b101011: w_alu_ctrl = 4'b1011;
        default:   w_alu_ctrl = 4'b1111;
      endcase
    end
  end

  always_comb begin
    w_alu_out = 32'h0;
    case (w_alu_ctrl)
      4'b0000:          w_alu_out = bus_a & bus_b;
      4'b0001:          w_alu_out = bus_a | bus_b;
      4'b0010, 4'b1000: w_alu_out = bus_a + bus_b;
      4'b0110, 4'b1001: w_alu_out = bus_a - bus_b;
      4'b0011:          w_alu_out = bus_b << shamt;
      4'b0100:          w_alu_out = bus_b >> shamt;
      4'b1101:          w_alu_out = $unsigned($signed(bus_b) >>> shamt);
      4'b0111:          w_alu_out = {31'h0, $signed(bus_a) < $signed(bus_b)};
      4'b1011:          w_alu_out = {31'h0, bus_a < bus_b};
      4'b1010:          w_alu_out = bus_a ^ bus_b;
      4'b1100:          w_alu_out = ~(bus_a | bus_b);
      4'b1110:          w_alu_out = {bus_b[15:0], 16'h0};
      default:          w_alu_out = 32'h0;
    endcase
  end

  assign alu_ctrl = w_alu_ctrl;
  assign alu_out  = w_alu_out;
  assign zero     = (w_alu_out == 32'h0);

  // Reset wins over a concurrent store, so a flushed SW never lands
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else if (mem_write) begin
      r_mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? r_mem[mem_addr] : 32'h0;
endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed + randomized bench for exec_mem_unit against a behavioural model.
module tb_exec_mem_unit;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [3:0]  alu_op;
  logic [5:0]  func_code;
  logic [31:0] bus_a, bus_b;
  logic [4:0]  shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [64];

  logic [5:0] fn_tab [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001,
                              6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                              6'b100111, 6'b101010, 6'b101011};
  logic [3:0] op_tab [13] = '{4'b0011, 4'b0100, 4'b1101, 4'b0010, 4'b1000,
                              4'b0110, 4'b1001, 4'b0000, 4'b0001, 4'b1010,
                              4'b1100, 4'b0111, 4'b1011};

  exec_mem_unit #(.DEPTH(64)) dut (
    .CLK(CLK), .Reset(Reset), .alu_op(alu_op), .func_code(func_code),
    .bus_a(bus_a), .bus_b(bus_b), .shamt(shamt), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .zero(zero), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] ref_ctrl(logic [3:0] op, logic [5:0] fn);
    if (op != 4'b1111) return op;
    for (int i = 0; i < 13; i++) if (fn_tab[i] == fn) return op_tab[i];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                          logic [4:0] s);
    case (c)
      4'd0:       return a & b;
      4'd1:       return a | b;
      4'd2, 4'd8: return a + b;
      4'd6, 4'd9: return a - b;
      4'd3:       return b << s;
      4'd4:       return b >> s;
      4'd13:      return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd7:       return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd11:      return (a < b) ? 32'd1 : 32'd0;
      4'd10:      return a ^ b;
      4'd12:      return ~(a | b);
      4'd14:      return b << 16;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu_set(logic [3:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                         logic [4:0] s);
    alu_op = op; func_code = fn; bus_a = a; bus_b = b; shamt = s;
    #1;
  endtask

  task automatic mem_op(logic rd, logic wr, logic [5:0] ad, logic [31:0] wd);
    mem_read = rd; mem_write = wr; mem_addr = ad; mem_wdata = wd;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    alu_set(4'h0, 6'h0, 32'h0, 32'h0, 5'h0);
    mem_op(1'b0, 1'b0, 6'h0, 32'h0);
    tick(); tick();
    Reset = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;

    mem_op(1'b1, 1'b0, 6'd0, 32'h0);  chk("rst_rd0", mem_rdata, 32'h0);
    mem_op(1'b1, 1'b0, 6'd63, 32'h0); chk("rst_rd63", mem_rdata, 32'h0);

    alu_set(4'hF, 6'b100000, 32'd7, 32'd5, 5'd0);
    chk("add_ctrl", {28'h0, alu_ctrl}, 32'h2);
    chk("add_out", alu_out, 32'd12);
    chk("add_zero", {31'h0, zero}, 32'h0);
    alu_set(4'hF, 6'b100010, 32'd9, 32'd9, 5'd0);
    chk("sub_out", alu_out, 32'h0);
    chk("sub_zero", {31'h0, zero}, 32'h1);
    alu_set(4'hF, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0); chk("slt", alu_out, 32'd1);
    alu_set(4'hF, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0); chk("sltu", alu_out, 32'd0);
    alu_set(4'hF, 6'b000011, 32'h0, 32'h8000_0000, 5'd4); chk("sra", alu_out, 32'hF800_0000);
    alu_set(4'hF, 6'b000010, 32'h0, 32'h8000_0000, 5'd4); chk("srl", alu_out, 32'h0800_0000);
    alu_set(4'hE, 6'h0, 32'h0, 32'h0000_1234, 5'd0);      chk("lui", alu_out, 32'h1234_0000);
    alu_set(4'h1, 6'h0, 32'hF0, 32'h0F, 5'd0);            chk("ori", alu_out, 32'hFF);
    alu_set(4'hF, 6'b111111, 32'h5, 32'h3, 5'd0);
    chk("bad_fn_ctrl", {28'h0, alu_ctrl}, 32'hF);
    chk("bad_fn_zero", {31'h0, zero}, 32'h1);
    alu_set(4'h5, 6'h0, 32'h5, 32'h3, 5'd0);              chk("op0101", alu_out, 32'h0);

    mem_op(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF); tick();
    mem_op(1'b1, 1'b0, 6'd5, 32'h0); chk("rd5", mem_rdata, 32'hDEAD_BEEF);
    mem_op(1'b1, 1'b0, 6'd6, 32'h0); chk("rd6", mem_rdata, 32'h0);
    mem_op(1'b0, 1'b0, 6'd5, 32'h0); chk("rd_off", mem_rdata, 32'h0);
    mem_op(1'b0, 1'b1, 6'd63, 32'hA5A5_0063); tick();
    mem_op(1'b0, 1'b1, 6'd0, 32'h5A5A_0000);  tick();
    mem_op(1'b1, 1'b0, 6'd63, 32'h0); chk("rd63", mem_rdata, 32'hA5A5_0063);
    mem_op(1'b1, 1'b0, 6'd0, 32'h0);  chk("rd0", mem_rdata, 32'h5A5A_0000);
    mem_op(1'b1, 1'b1, 6'd5, 32'h1111_2222); chk("rw_old", mem_rdata, 32'hDEAD_BEEF);
    tick();                                   chk("rw_new", mem_rdata, 32'h1111_2222);
    mem_op(1'b0, 1'b1, 6'd3, 32'h3333_3333); tick();
    Reset = 1'b1;
    mem_op(1'b0, 1'b1, 6'd7, 32'h7777_7777); tick();
    Reset = 1'b0;
    mem_op(1'b1, 1'b0, 6'd3, 32'h0); chk("rst_clr3", mem_rdata, 32'h0);
    mem_op(1'b1, 1'b0, 6'd7, 32'h0); chk("rst_drop7", mem_rdata, 32'h0);
    mem_op(1'b1, 1'b0, 6'd5, 32'h0); chk("rst_clr5", mem_rdata, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic [5:0] fn;
      logic [3:0] ec;
      op = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 12)] : 6'($urandom);
      alu_set(op, fn, $urandom, ($urandom_range(0, 7) == 0) ? bus_a : $urandom, 5'($urandom));
      ec = ref_ctrl(op, fn);
      chk("r_ctrl", {28'h0, alu_ctrl}, {28'h0, ec});
      chk("r_alu", alu_out, ref_alu(ec, bus_a, bus_b, shamt));
      chk("r_zero", {31'h0, zero}, {31'h0, ref_alu(ec, bus_a, bus_b, shamt) == 32'h0});
    end

    for (int n = 0; n < 400; n++) begin
      logic rd, wr, rs;
      logic [5:0]  ad;
      logic [31:0] wd;
      rd = 1'($urandom); wr = 1'($urandom); ad = 6'($urandom); wd = $urandom;
      rs = ($urandom_range(0, 59) == 0);
      Reset = rs;
      mem_op(rd, wr, ad, wd);
      chk("r_mem_pre", mem_rdata, rd ? ref_mem[ad] : 32'h0);
      tick();
      if (rs) foreach (ref_mem[i]) ref_mem[i] = 32'h0;
      else if (wr) ref_mem[ad] = wd;
      Reset = 1'b0;
      #1;
      chk("r_mem_post", mem_rdata, rd ? ref_mem[ad] : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
